// File: rtl/bird_ctrl.sv
// Game-logic stage: debounces the flap button, then once per frame steps the
// bird's vertical physics and the IDLE/PLAY/DEAD game state machine.
module bird_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int START_Y         = 228,
    parameter int BIRD_H          = 24,
    parameter int GROUND_Y        = 400,
    parameter int GRAVITY         = 1,
    parameter int FLAP_VEL        = -8,
    parameter int MAX_FALL        = 10,
    parameter int DEAD_FRAMES     = 30
) (
    input  logic        pix_clk,
    input  logic        pix_rst,
    input  logic        button,
    input  logic        frame_tick,
    input  logic        collide,
    output logic        flap,
    output logic [15:0] bird_y,
    output logic [7:0]  bird_vel,
    output logic [1:0]  game_state
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DF_W = $clog2(DEAD_FRAMES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DEAD = 2'd2
    } state_t;

    state_t          state, state_n;
    logic            sync1, btn_s, stable, stable_q, flap_req, req;
    logic [DB_W-1:0] db_cnt;
    logic [DF_W-1:0] dead_cnt, dead_cnt_n;
    logic [15:0]     y_n;
    logic [7:0]      vel_n, vel_sel;
    logic signed [9:0] vel_ext, vel_inc;
    logic [16:0]     y_sum;
    logic            hit_ground;

    // Button conditioning: synchronizer, debounce, rising-edge pulse.
    always_ff @(posedge pix_clk) begin
        if (pix_rst) begin
            sync1    <= 1'b0;
            btn_s    <= 1'b0;
            stable   <= 1'b0;
            stable_q <= 1'b0;
            db_cnt   <= '0;
            flap     <= 1'b0;
            flap_req <= 1'b0;
        end else begin
            sync1    <= button;
            btn_s    <= sync1;
            stable_q <= stable;
            flap     <= stable & ~stable_q;
            if (btn_s == stable) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                stable <= btn_s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
            // A tick consumes any pending request, including one arriving with it.
            if (frame_tick)
                flap_req <= 1'b0;
            else if (flap)
                flap_req <= 1'b1;
        end
    end

    assign req = flap_req | flap;

    // Velocity is resolved first; position uses the new velocity.
    assign vel_ext    = {{2{bird_vel[7]}}, bird_vel};
    assign vel_inc    = vel_ext + 10'(GRAVITY);
    assign vel_sel    = req ? 8'(FLAP_VEL)
                      : ((vel_inc > $signed(10'(MAX_FALL))) ? 8'(MAX_FALL) : vel_inc[7:0]);
    assign y_sum      = {1'b0, bird_y} + {{9{vel_sel[7]}}, vel_sel};
    assign hit_ground = (y_sum + 17'(BIRD_H)) >= 17'(GROUND_Y);

    always_ff @(posedge pix_clk) begin
        if (pix_rst) begin
            state    <= IDLE;
            bird_y   <= 16'(START_Y);
            bird_vel <= '0;
            dead_cnt <= '0;
        end else begin
            state    <= state_n;
            bird_y   <= y_n;
            bird_vel <= vel_n;
            dead_cnt <= dead_cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        y_n        = bird_y;
        vel_n      = bird_vel;
        dead_cnt_n = dead_cnt;
        if (frame_tick) begin
            case (state)
                IDLE: begin
                    y_n   = 16'(START_Y);
                    vel_n = '0;
                    if (req) begin
                        state_n = PLAY;
                        vel_n   = 8'(FLAP_VEL);
                        y_n     = 16'(START_Y + FLAP_VEL);
                    end
                end
                PLAY: begin
                    vel_n = vel_sel;
                    y_n   = y_sum[15:0];
                    if (y_sum[16]) begin
                        y_n   = '0;
                        vel_n = '0;
                    end else if (hit_ground) begin
                        y_n     = 16'(GROUND_Y - BIRD_H);
                        vel_n   = '0;
                        state_n = DEAD;
                    end
                    if (collide)
                        state_n = DEAD;
                end
                DEAD: begin
                    if (dead_cnt == DF_W'(DEAD_FRAMES)) begin
                        if (req) begin
                            state_n    = IDLE;
                            y_n        = 16'(START_Y);
                            vel_n      = '0;
                            dead_cnt_n = '0;
                        end
                    end else begin
                        dead_cnt_n = dead_cnt + DF_W'(1);
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign game_state = state;

endmodule
